// File: rtl/rab_arbiter.sv
// Round-robin arbiter between the MCU and I2C-slave masters for the shared register access bus.
// Issues one single-strobe RAB transfer per grant and waits for the slave ack, with a timeout.
module rab_arbiter #(
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          mcu_req,
  input  logic          mcu_wr,
  input  logic [AW-1:0] mcu_addr,
  input  logic [DW-1:0] mcu_wdata,
  output logic          mcu_done,
  output logic [DW-1:0] mcu_rdata,
  output logic          mcu_err,
  input  logic          i2cs_req,
  input  logic          i2cs_wr,
  input  logic [AW-1:0] i2cs_addr,
  input  logic [DW-1:0] i2cs_wdata,
  output logic          i2cs_done,
  output logic [DW-1:0] i2cs_rdata,
  output logic          i2cs_err,
  output logic          rab_write,
  output logic          rab_read,
  output logic [AW-1:0] rab_addr,
  output logic [DW-1:0] rab_wdata,
  input  logic [DW-1:0] rab_rdata,
  input  logic          rab_ack,
  output logic          mcu_rab_write,
  output logic          mcu_rab_read,
  output logic          i2cs_rab_write,
  output logic          i2cs_rab_read,
  output logic          rab_busy
);

  localparam int unsigned   CW     = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO    = CW'(TIMEOUT);
  localparam logic          M_MCU  = 1'b0;
  localparam logic          M_I2CS = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STROBE = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t        r_state;
  logic          r_grant;
  logic          r_last_grant;
  logic          r_wr;
  logic [CW-1:0] r_cnt;

  logic          w_grant_i2cs;
  logic          w_sel_wr;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;
  logic [CW-1:0] w_cnt_inc;
  logic          w_timeout;
  logic          w_finish;
  logic [DW-1:0] w_cap_rdata;

  // On a tie the master that was not served last wins.
  assign w_grant_i2cs = i2cs_req & (~mcu_req | (r_last_grant == M_MCU));
  assign w_sel_wr     = w_grant_i2cs ? i2cs_wr    : mcu_wr;
  assign w_sel_addr   = w_grant_i2cs ? i2cs_addr  : mcu_addr;
  assign w_sel_wdata  = w_grant_i2cs ? i2cs_wdata : mcu_wdata;

  // Saturating wait counter; an ack on the final sample still wins over the timeout.
  assign w_cnt_inc   = (r_cnt == TMO) ? r_cnt : r_cnt + CW'(1);
  assign w_timeout   = (w_cnt_inc == TMO);
  assign w_finish    = rab_ack | w_timeout;
  assign w_cap_rdata = rab_ack ? rab_rdata : {DW{1'b1}};

  assign mcu_rab_write  = rab_write & (r_grant == M_MCU);
  assign mcu_rab_read   = rab_read  & (r_grant == M_MCU);
  assign i2cs_rab_write = rab_write & (r_grant == M_I2CS);
  assign i2cs_rab_read  = rab_read  & (r_grant == M_I2CS);

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state      <= S_IDLE;
      r_grant      <= M_MCU;
      r_last_grant <= M_I2CS;
      r_wr         <= 1'b0;
      r_cnt        <= '0;
      rab_write    <= 1'b0;
      rab_read     <= 1'b0;
      rab_addr     <= '0;
      rab_wdata    <= '0;
      rab_busy     <= 1'b0;
      mcu_done     <= 1'b0;
      mcu_rdata    <= '0;
      mcu_err      <= 1'b0;
      i2cs_done    <= 1'b0;
      i2cs_rdata   <= '0;
      i2cs_err     <= 1'b0;
    end else begin
      rab_write <= 1'b0;
      rab_read  <= 1'b0;
      mcu_done  <= 1'b0;
      i2cs_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (mcu_req | i2cs_req) begin
            r_grant   <= w_grant_i2cs;
            r_wr      <= w_sel_wr;
            rab_addr  <= w_sel_addr;
            rab_wdata <= w_sel_wdata;
            rab_write <= w_sel_wr;
            rab_read  <= ~w_sel_wr;
            rab_busy  <= 1'b1;
            r_cnt     <= '0;
            r_state   <= S_STROBE;
          end
        end
        S_STROBE, S_WAIT: begin
          r_cnt <= w_cnt_inc;
          if (w_finish) begin
            r_state <= S_DONE;
            if (r_grant == M_I2CS) begin
              i2cs_done <= 1'b1;
              i2cs_err  <= ~rab_ack;
              if (!r_wr) i2cs_rdata <= w_cap_rdata;
            end else begin
              mcu_done <= 1'b1;
              mcu_err  <= ~rab_ack;
              if (!r_wr) mcu_rdata <= w_cap_rdata;
            end
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_DONE: begin
          r_last_grant <= r_grant;
          rab_busy     <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: begin
          rab_busy <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rab_arbiter.sv
// Self-checking bench for rab_arbiter: vector table for single transfers, hand sequences for
// ties, fairness and reset, with a completion scoreboard checked by a slave/monitor process.
module tb_rab_arbiter;

  localparam int TMO = 15;

  logic        sys_clk;
  logic        sys_rst;
  logic        mcu_req, mcu_wr, i2cs_req, i2cs_wr;
  logic [15:0] mcu_addr, i2cs_addr, rab_addr;
  logic [7:0]  mcu_wdata, i2cs_wdata, rab_wdata, rab_rdata;
  logic        mcu_done, i2cs_done, mcu_err, i2cs_err;
  logic [7:0]  mcu_rdata, i2cs_rdata;
  logic        rab_write, rab_read, rab_ack, rab_busy;
  logic        mcu_rab_write, mcu_rab_read, i2cs_rab_write, i2cs_rab_read;

  rab_arbiter #(.AW(16), .DW(8), .TIMEOUT(TMO)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .mcu_req(mcu_req), .mcu_wr(mcu_wr), .mcu_addr(mcu_addr), .mcu_wdata(mcu_wdata),
    .mcu_done(mcu_done), .mcu_rdata(mcu_rdata), .mcu_err(mcu_err),
    .i2cs_req(i2cs_req), .i2cs_wr(i2cs_wr), .i2cs_addr(i2cs_addr), .i2cs_wdata(i2cs_wdata),
    .i2cs_done(i2cs_done), .i2cs_rdata(i2cs_rdata), .i2cs_err(i2cs_err),
    .rab_write(rab_write), .rab_read(rab_read), .rab_addr(rab_addr), .rab_wdata(rab_wdata),
    .rab_rdata(rab_rdata), .rab_ack(rab_ack),
    .mcu_rab_write(mcu_rab_write), .mcu_rab_read(mcu_rab_read),
    .i2cs_rab_write(i2cs_rab_write), .i2cs_rab_read(i2cs_rab_read),
    .rab_busy(rab_busy)
  );

  typedef struct {
    bit          m;      // 0 = MCU, 1 = I2CS
    bit          wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          k;      // ack delay after strobe, -1 = never
    logic [7:0]  sdata;
    logic [7:0]  exp_rdata;
    bit          exp_err;
    int          lat;    // cycles from request drive to done
  } vec_t;

  typedef struct {
    bit          m;
    bit          wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    bit          err;
    int          due;    // -1 = derive from strobe time
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   mcu_dn = 0, i2cs_dn = 0;
  int   n_mw = 0, n_mr = 0, n_iw = 0, n_ir = 0;
  int   slv_k;
  logic [7:0] slv_data;
  bit   stray;
  exp_t exp_q[$];
  vec_t vecs[7];

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Slave responder and completion monitor, all on the falling edge.
  int         ack_at = -1;
  int         cur_due = 0;
  exp_t       me;
  logic [3:0] qexp;
  always @(negedge sys_clk) begin
    rab_ack   = 1'b0;
    rab_rdata = 8'hEE;
    if (!sys_rst) begin
      ack_at = -1;
    end else begin
      if (rab_read | rab_write) begin
        n_mw += int'(mcu_rab_write);
        n_mr += int'(mcu_rab_read);
        n_iw += int'(i2cs_rab_write);
        n_ir += int'(i2cs_rab_read);
        if (exp_q.size() == 0) begin
          chk("strobe_unexp", {rab_write, rab_read}, 2'b00);
        end else begin
          me   = exp_q[0];
          qexp = me.m ? {2'b00, me.wr, ~me.wr} : {me.wr, ~me.wr, 2'b00};
          chk("qual_strobe", {mcu_rab_write, mcu_rab_read, i2cs_rab_write, i2cs_rab_read}, qexp);
          chk("strobe_addr", rab_addr, me.addr);
          if (me.wr) chk("strobe_wdata", rab_wdata, me.wdata);
          cur_due = (slv_k < 0) ? cyc + TMO : cyc + 1 + slv_k;
          ack_at  = (slv_k < 0) ? -1 : cyc + slv_k;
        end
      end
      if (ack_at >= 0 && cyc == ack_at) begin
        rab_ack   = 1'b1;
        rab_rdata = slv_data;
        ack_at    = -1;
      end
      if (stray) rab_ack = 1'b1;
      if (rab_busy && exp_q.size() > 0) chk("addr_hold", rab_addr, exp_q[0].addr);
      if (mcu_done | i2cs_done) begin
        mcu_dn  += int'(mcu_done);
        i2cs_dn += int'(i2cs_done);
        if (exp_q.size() == 0) begin
          chk("done_unexp", {mcu_done, i2cs_done}, 2'b00);
        end else begin
          me = exp_q.pop_front();
          chk("done_onehot", {mcu_done, i2cs_done}, me.m ? 2'b01 : 2'b10);
          chk("done_rdata", me.m ? i2cs_rdata : mcu_rdata, me.rdata);
          chk("done_err", me.m ? i2cs_err : mcu_err, me.err);
          chk("done_time", cyc, (me.due >= 0) ? me.due : cur_due);
        end
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #2;
  endtask

  task automatic wait_dn(input bit m, input int start);
    for (int i = 0; i < 60; i++) begin
      tick();
      if ((m ? i2cs_dn : mcu_dn) != start) return;
    end
    chk(m ? "i2cs_done_wait" : "mcu_done_wait", m ? i2cs_dn : mcu_dn, start + 1);
  endtask

  task automatic drive_req(input bit m, input bit wr, input logic [15:0] addr,
                           input logic [7:0] wdata);
    if (m) begin
      i2cs_wr = wr; i2cs_addr = addr; i2cs_wdata = wdata; i2cs_req = 1'b1;
    end else begin
      mcu_wr = wr; mcu_addr = addr; mcu_wdata = wdata; mcu_req = 1'b1;
    end
  endtask

  task automatic drop_req(input bit m);
    if (m) i2cs_req = 1'b0;
    else   mcu_req  = 1'b0;
  endtask

  task automatic push(input bit m, input bit wr, input logic [15:0] addr, input logic [7:0] wdata,
                      input logic [7:0] rdata, input bit err, input int due);
    exp_q.push_back(exp_t'{m: m, wr: wr, addr: addr, wdata: wdata, rdata: rdata, err: err, due: due});
  endtask

  task automatic run_vec(input vec_t v);
    int start;
    slv_k    = v.k;
    slv_data = v.sdata;
    start    = v.m ? i2cs_dn : mcu_dn;
    drive_req(v.m, v.wr, v.addr, v.wdata);
    push(v.m, v.wr, v.addr, v.wdata, v.exp_rdata, v.exp_err, cyc + v.lat);
    wait_dn(v.m, start);
    drop_req(v.m);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int sm, si, st, q0, q1, q2, q3;
    vecs[0] = '{m: 0, wr: 0, addr: 16'h1234, wdata: 8'h00, k: 0,  sdata: 8'hA5, exp_rdata: 8'hA5, exp_err: 0, lat: 2};
    vecs[1] = '{m: 1, wr: 0, addr: 16'h0300, wdata: 8'h00, k: -1, sdata: 8'h00, exp_rdata: 8'hFF, exp_err: 1, lat: 16};
    vecs[2] = '{m: 1, wr: 1, addr: 16'h0040, wdata: 8'h77, k: 2,  sdata: 8'h12, exp_rdata: 8'hFF, exp_err: 0, lat: 4};
    vecs[3] = '{m: 0, wr: 0, addr: 16'h00C3, wdata: 8'h00, k: 5,  sdata: 8'h3C, exp_rdata: 8'h3C, exp_err: 0, lat: 7};
    vecs[4] = '{m: 0, wr: 1, addr: 16'hBEEF, wdata: 8'h11, k: 14, sdata: 8'h66, exp_rdata: 8'h3C, exp_err: 0, lat: 16};
    vecs[5] = '{m: 1, wr: 0, addr: 16'h0301, wdata: 8'h00, k: 1,  sdata: 8'h5C, exp_rdata: 8'h5C, exp_err: 0, lat: 3};
    vecs[6] = '{m: 0, wr: 1, addr: 16'h0002, wdata: 8'h9D, k: -1, sdata: 8'h00, exp_rdata: 8'h3C, exp_err: 1, lat: 16};

    sys_rst = 1'b0; stray = 1'b0; slv_k = -1; slv_data = 8'h00;
    mcu_req = 1'b0; mcu_wr = 1'b0; mcu_addr = '0; mcu_wdata = '0;
    i2cs_req = 1'b0; i2cs_wr = 1'b0; i2cs_addr = '0; i2cs_wdata = '0;
    repeat (3) tick();
    chk("rst_busy", rab_busy, 1'b0);
    chk("rst_strobes", {rab_write, rab_read}, 2'b00);
    sys_rst = 1'b1;
    tick();
    chk("rst_done", {mcu_done, i2cs_done, mcu_err, i2cs_err}, 4'h0);
    chk("rst_rdata", {mcu_rdata, i2cs_rdata}, 16'h0000);
    chk("rst_bus", {rab_addr, rab_wdata}, 24'h0);

    // Tie after reset: MCU first, then I2CS, one write strobe each.
    slv_k = 0; slv_data = 8'h00;
    sm = mcu_dn; si = i2cs_dn;
    q0 = n_mw; q1 = n_iw; q2 = n_mr; q3 = n_ir;
    drive_req(1'b0, 1'b1, 16'h0010, 8'h5A);
    drive_req(1'b1, 1'b1, 16'h0020, 8'hC3);
    push(1'b0, 1'b1, 16'h0010, 8'h5A, 8'h00, 1'b0, -1);
    push(1'b1, 1'b1, 16'h0020, 8'hC3, 8'h00, 1'b0, -1);
    wait_dn(1'b0, sm);
    drop_req(1'b0);
    wait_dn(1'b1, si);
    drop_req(1'b1);
    chk("tie_mcu_wr_pulses", n_mw - q0, 1);
    chk("tie_i2cs_wr_pulses", n_iw - q1, 1);
    chk("tie_rd_pulses", (n_mr - q2) + (n_ir - q3), 0);
    tick();

    for (int i = 0; i < 7; i++) begin
      if (i == 3) begin
        stray = 1'b1;
        repeat (3) tick();
        chk("stray_busy", rab_busy, 1'b0);
        chk("stray_done", {mcu_done, i2cs_done}, 2'b00);
        stray = 1'b0;
        tick();
      end
      run_vec(vecs[i]);
    end
    tick();

    // Fairness: both held; last served was MCU so I2CS leads.
    slv_k = 0; slv_data = 8'h42;
    st = mcu_dn + i2cs_dn;
    drive_req(1'b0, 1'b0, 16'h0A0A, 8'h00);
    drive_req(1'b1, 1'b0, 16'h0B0B, 8'h00);
    for (int i = 0; i < 6; i++)
      push(((i % 2) == 0), 1'b0, ((i % 2) == 0) ? 16'h0B0B : 16'h0A0A, 8'h00, 8'h42, 1'b0, -1);
    for (int i = 0; i < 120; i++) begin
      tick();
      if (mcu_dn + i2cs_dn >= st + 6) break;
    end
    chk("fair_count", mcu_dn + i2cs_dn, st + 6);
    drop_req(1'b0);
    drop_req(1'b1);
    repeat (2) tick();
    chk("fair_idle", rab_busy, 1'b0);

    // Reset while waiting for an ack that never comes.
    slv_k = -1;
    drive_req(1'b1, 1'b0, 16'h0C0C, 8'h00);
    push(1'b1, 1'b0, 16'h0C0C, 8'h00, 8'hFF, 1'b1, -1);
    repeat (6) tick();
    chk("mid_busy", rab_busy, 1'b1);
    sys_rst = 1'b0;
    #1;
    chk("arst_busy", rab_busy, 1'b0);
    chk("arst_strobes", {rab_write, rab_read, i2cs_rab_read}, 3'b000);
    chk("arst_done", {mcu_done, i2cs_done}, 2'b00);
    exp_q.delete();
    drop_req(1'b1);
    repeat (2) tick();
    chk("arst_rdata", {mcu_rdata, i2cs_rdata}, 16'h0000);
    sys_rst = 1'b1;
    tick();

    // Tie after reset: MCU wins even though it was served last before reset.
    slv_k = 1; slv_data = 8'h99;
    sm = mcu_dn; si = i2cs_dn;
    drive_req(1'b0, 1'b0, 16'h0100, 8'h00);
    drive_req(1'b1, 1'b0, 16'h0200, 8'h00);
    push(1'b0, 1'b0, 16'h0100, 8'h00, 8'h99, 1'b0, -1);
    push(1'b1, 1'b0, 16'h0200, 8'h00, 8'h99, 1'b0, -1);
    wait_dn(1'b0, sm);
    drop_req(1'b0);
    wait_dn(1'b1, si);
    drop_req(1'b1);
    repeat (3) tick();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
